// File: rtl/arith_sched_pkg.sv
// +----------------------------------------------------------------------+
// | arith_sched_pkg: opcodes, FSM states and single-cycle result function |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package arith_sched_pkg;

  localparam int MAXW = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR  = 4'd1,  OP_XOR = 4'd2,  OP_ADD = 4'd3,
    OP_SUB  = 4'd4,  OP_MUL = 4'd5,  OP_DIV = 4'd6,  OP_LAND = 4'd7,
    OP_LOR  = 4'd8,  OP_EQ  = 4'd9,  OP_NE  = 4'd10, OP_LT  = 4'd11,
    OP_LE   = 4'd12, OP_GE  = 4'd13, OP_GT  = 4'd14, OP_ILL = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Operands arrive zero-extended to MAXW; callers truncate to 2*WIDTH,
  // which keeps SUB correct modulo 2^(2*WIDTH).
  function automatic logic [2*MAXW-1:0] alu_result(input op_e op,
                                                   input logic [MAXW-1:0] a,
                                                   input logic [MAXW-1:0] b);
    logic [2*MAXW-1:0] ax, bx, res;
    ax  = {{MAXW{1'b0}}, a};
    bx  = {{MAXW{1'b0}}, b};
    res = '0;
    case (op)
      OP_AND:  res = ax & bx;
      OP_OR:   res = ax | bx;
      OP_XOR:  res = ax ^ bx;
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_MUL:  res = ax * bx;
      OP_LAND: res[0] = (a != '0) && (b != '0);
      OP_LOR:  res[0] = (a != '0) || (b != '0);
      OP_EQ:   res[0] = (a == b);
      OP_NE:   res[0] = (a != b);
      OP_LT:   res[0] = (a < b);
      OP_LE:   res[0] = (a <= b);
      OP_GE:   res[0] = (a >= b);
      OP_GT:   res[0] = (a > b);
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arith_sched_div.sv
// +----------------------------------------------------------------------+
// | arith_sched_div: WIDTH-cycle restoring divider (ARITH_SCHED_DIV_EN)   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module arith_sched_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem, quo, div;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH-1:0] cur_rem, cur_quo, cur_div, nxt_rem, nxt_quo;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // The first iteration runs on the start cycle straight from the operands.
  always_comb begin
    cur_rem = start ? '0 : rem;
    cur_quo = start ? a  : quo;
    cur_div = start ? b  : div;
    shifted = {cur_rem, cur_quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, cur_div});
    nxt_rem = ge ? WIDTH'(shifted - {1'b0, cur_div}) : shifted[WIDTH-1:0];
    nxt_quo = WIDTH'({cur_quo, ge});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      div  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= nxt_rem;
        quo  <= nxt_quo;
        div  <= b;
        cnt  <= CW'(1);
        busy <= (WIDTH > 1);
        done <= (WIDTH == 1);
      end else if (busy) begin
        rem <= nxt_rem;
        quo <= nxt_quo;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

`default_nettype wire

// File: rtl/arith_sched.sv
// +----------------------------------------------------------------------+
// | arith_sched: round-robin sequencer sharing one ALU among NREQ users;  |
// | iterative DIV present only when ARITH_SCHED_DIV_EN is defined.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module arith_sched
  import arith_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*4-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  rsp_err
);

  state_e           state;
  logic [IDW-1:0]   rr_ptr, gnt_idx, next_ptr, off;
  logic [IDW:0]     sum;
  logic [NREQ-1:0]  rot;
  logic             found, fire;
  op_e              sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> rr_ptr);
    found = 1'b0;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    sum     = {1'b0, rr_ptr} + {1'b0, off};
    gnt_idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
  end

  assign fire      = rst_n && (state == ST_IDLE) && found;
  assign req_ready = fire ? (NREQ'(1) << gnt_idx) : '0;
  assign next_ptr  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  assign sel_op    = op_e'(4'(req_op >> {gnt_idx, 2'b00}));
  assign sel_a     = WIDTH'(req_a >> (int'(gnt_idx) * WIDTH));
  assign sel_b     = WIDTH'(req_b >> (int'(gnt_idx) * WIDTH));

`ifdef ARITH_SCHED_DIV_EN
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign div_start = fire && (sel_op == OP_DIV) && (sel_b != '0);

  arith_sched_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .a         (sel_a),
    .b         (sel_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire) begin
            rr_ptr <= next_ptr;
            rsp_id <= gnt_idx;
            if (sel_op == OP_DIV) begin
`ifdef ARITH_SCHED_DIV_EN
              if (sel_b != '0) begin
                state <= ST_DIVIDE;
              end else begin
                rsp_data  <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= ST_RESP;
              end
`else
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
`endif
            end else begin
              rsp_data  <= (2*WIDTH)'(alu_result(sel_op, MAXW'(sel_a), MAXW'(sel_b)));
              rsp_err   <= (sel_op == OP_ILL);
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
`ifdef ARITH_SCHED_DIV_EN
        ST_DIVIDE: begin
          if (div_done) begin
            rsp_data  <= {div_rem, div_quo};
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arith_sched.sv
// +----------------------------------------------------------------------+
// | tb_arith_sched: directed self-checking bench for arith_sched          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_arith_sched;
  import arith_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [7:0] req_op = '0, req_a = '0, req_b = '0;
  logic       rsp_valid, rsp_err;
  logic       rsp_ready = 1'b1;
  logic [2:0] rsp_id;
  logic [7:0] rsp_data;
  int         checks = 0, failures = 0;
  int         n;

`ifdef ARITH_SCHED_DIV_EN
  localparam logic [7:0] DIV_D = 8'h13;
  localparam logic       DIV_E = 1'b0;
  localparam int         DIV_L = 5;
  localparam logic [7:0] DZ_D  = 8'h0F;
`else
  localparam logic [7:0] DIV_D = 8'h00;
  localparam logic       DIV_E = 1'b1;
  localparam int         DIV_L = 1;
  localparam logic [7:0] DZ_D  = 8'h00;
`endif

  always #5 clk = ~clk;

  arith_sched #(.NREQ(2), .WIDTH(4), .IDW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure handshake-to-rsp_valid latency, check, then drain.
  task automatic run_op(input int i, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp_d,
                        input logic exp_e, input int exp_lat, input string tag);
    int w, lat;
    @(negedge clk);
    req_op[4*i +: 4] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
    req_valid[i]     = 1'b1;
    #1;
    w = 0;
    while (!req_ready[i] && w < 50) begin @(negedge clk); #1; w++; end
    chk({tag, "_grant"}, 32'(req_ready[i]), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) req_valid[i] = 1'b0;
    end while (!rsp_valid && lat < 40);
    chk({tag, "_lat"},  32'(lat),      32'(exp_lat));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, "_id"},   32'(rsp_id),   32'(i));
    chk({tag, "_err"},  32'(rsp_err),  32'(exp_e));
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state, with both requesters already valid
    req_op = 8'h33; req_a = 8'h11; req_b = 8'h11; req_valid = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err}), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    run_op(0, OP_ADD,  4'd9,  4'd8,  8'h11, 1'b0, 1, "add");
    run_op(0, OP_SUB,  4'd3,  4'd5,  8'hFE, 1'b0, 1, "sub");
    run_op(1, OP_MUL,  4'd15, 4'd15, 8'hE1, 1'b0, 1, "mul");
    run_op(1, OP_GT,   4'd7,  4'd2,  8'h01, 1'b0, 1, "gt");
    run_op(0, OP_LAND, 4'd4,  4'd0,  8'h00, 1'b0, 1, "land");
    run_op(1, OP_XOR,  4'hA,  4'h6,  8'h0C, 1'b0, 1, "xor");
    run_op(0, OP_LE,   4'd5,  4'd5,  8'h01, 1'b0, 1, "le");
    run_op(1, OP_ILL,  4'd3,  4'd3,  8'h00, 1'b1, 1, "illegal");
    run_op(0, OP_DIV,  4'd13, 4'd4,  DIV_D, DIV_E, DIV_L, "div");
    run_op(1, OP_DIV,  4'd7,  4'd0,  DZ_D,  1'b1, 1, "div0");

    // Back-pressure: response must hold and no grant may issue
    @(negedge clk);
    rsp_ready = 1'b0;
    req_op[7:4] = OP_MUL; req_a[7:4] = 4'd6; req_b[7:4] = 4'd7; req_valid[1] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[1] && n < 50) begin @(negedge clk); #1; n++; end
    chk("stall_grant", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_op[3:0] = OP_ADD; req_a[3:0] = 4'd1; req_b[3:0] = 4'd1; req_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk("stall_hold", 32'({req_ready, rsp_valid, rsp_id, rsp_err, rsp_data}),
          32'({2'b00, 1'b1, 3'd1, 1'b0, 8'h2A}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("release_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 3'd0, 8'h02}));
    @(posedge clk); #1;

    // Reset while an op is in flight (mid-DIVIDE when the divider exists)
    @(negedge clk);
    rsp_ready = 1'b0;
`ifdef ARITH_SCHED_DIV_EN
    req_op[3:0] = OP_DIV;
`else
    req_op[3:0] = OP_ADD;
`endif
    req_a[3:0] = 4'd13; req_b[3:0] = 4'd4; req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge clk); #1; n++; end
    chk("mid_grant", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_op = 8'h33; req_a = 8'h21; req_b = 8'h21;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;

    // Both requesters valid: grants alternate starting at requester 0
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
      chk("rr_grant", 32'(req_ready), 32'(1 << (g % 2)));
      @(posedge clk); #1;
      chk("rr_valid", 32'(rsp_valid), 32'd1);
      chk("rr_id",    32'(rsp_id),    32'(g % 2));
      chk("rr_data",  32'(rsp_data),  (g % 2) ? 32'h4 : 32'h2);
    end
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arith_sched.md
Name: arith_sched

Overview:
- Sequencer and arbiter that shares one unsigned arithmetic/logic/compare datapath between NREQ requesters.
- Operation set: AND, OR, XOR, ADD, SUB, MUL, DIV, logical AND/OR, six compares.
- Requesters use valid/ready to submit (op, a, b) and receive a tagged, registered result on a single response channel.
- DIV is iterative (multi-cycle); all other ops complete in one cycle.
- Sits between request sources and the arithmetic unit; one operation in flight at a time.

Parameters:
- NREQ, 2, number of requesters (2..8)
- WIDTH, 4, operand width in bits; results are 2*WIDTH bits
- IDW, 3, width of the rsp_id tag (must satisfy 2**IDW >= NREQ)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_op  in  NREQ*4  per-requester opcode, requester i at bits [4i+3:4i]
- req_a  in  NREQ*WIDTH  per-requester operand a
- req_b  in  NREQ*WIDTH  per-requester operand b
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_data  out  2*WIDTH  result
- rsp_err  out  1  error flag: divide-by-zero, illegal opcode, or DIV compiled out

Behaviour:
- Opcodes (pkg): AND=0, OR=1, XOR=2, ADD=3, SUB=4, MUL=5, DIV=6, LAND=7, LOR=8, EQ=9, NE=10, LT=11, LE=12, GE=13, GT=14. Opcode 15 is illegal.
- States: IDLE, DIVIDE, RESP.
- req_ready[i] is combinational: 1 only in IDLE for the round-robin winner among asserted req_valid. Search starts at rr_ptr. Never more than one bit set.
- Handshake in IDLE (req_valid[i] & req_ready[i]):
  - Capture op/a/b and id=i.
  - rr_ptr <= (i+1) mod NREQ.
  - Non-DIV ops: compute and register result, go to RESP. rsp_valid rises the next cycle (latency 1).
  - DIV with b!=0: go to DIVIDE, run a restoring divider for exactly WIDTH cycles, then go to RESP. rsp_valid rises WIDTH+1 cycles after the handshake.
  - DIV with b==0: go straight to RESP with rsp_data = {WIDTH'0, all-ones quotient} and rsp_err=1.
- Arithmetic, all operands unsigned, result 2*WIDTH bits:
  - AND/OR/XOR: zero-extended.
  - ADD: carry kept in bit WIDTH.
  - SUB: (a-b) mod 2^(2*WIDTH).
  - MUL: full product.
  - DIV: {remainder, quotient}.
  - LAND/LOR: (a!=0)&&(b!=0) and (a!=0)||(b!=0).
  - Compares: 1-bit result in bit 0, upper bits zero.
- Illegal opcode: rsp_data=0, rsp_err=1, latency 1.
- RESP: rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE. The next grant happens no earlier than the following cycle. Maximum throughput is one op per 2 cycles.
- Requests arriving while busy stall (req_ready=0). Request payloads are not required to be stable before their grant.
- Reset (any state, including mid-DIVIDE):
  - state=IDLE, rr_ptr=0, divider registers cleared, in-flight result dropped.
  - Outputs: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, req_ready=0 during the reset cycle.

Optional Feature:
- ARITH_SCHED_DIV_EN defined: iterative divider and DIVIDE state present, as described above.
- ARITH_SCHED_DIV_EN undefined: no divider logic and no DIVIDE state. DIV behaves as illegal: latency 1, rsp_data=0, rsp_err=1.

Decomposition:
- Package arith_sched_pkg holds:
  - opcode enum (4-bit)
  - state enum
  - function computing the single-cycle result for (op, a, b) at a given width
- One natural sub-module: arith_sched_div, the iterative restoring divider.
  - Interface: start, a, b, done, quotient, remainder.
  - Instantiated only under ARITH_SCHED_DIV_EN.

Test Plan:
- W=4, single requester 0, ADD a=9 b=8 -> rsp_valid 1 cycle after handshake, rsp_data=0x11, rsp_id=0, rsp_err=0.
- SUB a=3 b=5 -> rsp_data=0xFE. MUL a=15 b=15 -> 0xE1. GT a=7 b=2 -> 0x01. LAND a=4 b=0 -> 0x00.
- DIV a=13 b=4 (DIV_EN) -> rsp_valid 5 cycles after handshake, rsp_data=0x13 (rem 1, quo 3). DIV b=0 -> rsp_data=0x0F, rsp_err=1, latency 1.
- Both requesters continuously valid -> grants alternate 0,1,0,1; rsp_id matches the granted requester; req_ready never two-hot.
- rsp_ready held low 10 cycles -> response fields stable, no new req_ready; release -> IDLE, next grant 1 cycle later.
- rst_n low for one cycle mid-DIVIDE -> next cycle rsp_valid=0, state IDLE, no response emitted, rr_ptr=0 (requester 0 wins next).
